// File: rtl/generic_dpram_pkg.sv
// Shared constants for the single-clock dual-port RAM used by the VGA/LCD line FIFOs.
package generic_dpram_pkg;

  localparam int DPRAM_AWIDTH = 7;
  localparam int DPRAM_DWIDTH = 16;

endpackage : generic_dpram_pkg

// File: rtl/generic_dpram_1clk_array.sv
// Raw storage array: synchronous write port and an asynchronous read tap,
// shaped so synthesis can map it onto block RAM.
module dpram_array
  import generic_dpram_pkg::*;
#(
  parameter int AWIDTH = DPRAM_AWIDTH,
  parameter int DWIDTH = DPRAM_DWIDTH
) (
  input  logic              clk,
  input  logic              aclr,
  input  logic              wce,
  input  logic              we,
  input  logic [AWIDTH-1:0] waddr,
  input  logic [DWIDTH-1:0] di,
  input  logic [AWIDTH-1:0] raddr,
  output logic [DWIDTH-1:0] rdata
);

  logic [DWIDTH-1:0] mem [0:(2**AWIDTH)-1];

  // Contents are never cleared; reset only blocks the write.
  always_ff @(posedge clk) begin
    if (aclr && wce && we) begin
      mem[waddr] <= di;
    end
  end

  assign rdata = mem[raddr];

endmodule : dpram_array

// File: rtl/generic_dpram_1clk.sv
// Single-clock simple dual-port RAM with a registered read port and oe gating.
// Define GENERIC_DPRAM_BYPASS_EN for write-through on same-address read/write.
module generic_dpram_1clk
  import generic_dpram_pkg::*;
#(
  parameter int AWIDTH = DPRAM_AWIDTH,
  parameter int DWIDTH = DPRAM_DWIDTH
) (
  input  logic              clk,
  input  logic              aclr,
  input  logic              rce,
  input  logic              oe,
  input  logic [AWIDTH-1:0] raddr,
  output logic [DWIDTH-1:0] dout,
  input  logic              wce,
  input  logic              we,
  input  logic [AWIDTH-1:0] waddr,
  input  logic [DWIDTH-1:0] di
);

  logic [DWIDTH-1:0] array_rdata;
  logic [DWIDTH-1:0] read_next;
  logic [DWIDTH-1:0] rdata_q;

  dpram_array #(
    .AWIDTH(AWIDTH),
    .DWIDTH(DWIDTH)
  ) u_array (
    .clk  (clk),
    .aclr (aclr),
    .wce  (wce),
    .we   (we),
    .waddr(waddr),
    .di   (di),
    .raddr(raddr),
    .rdata(array_rdata)
  );

`ifdef GENERIC_DPRAM_BYPASS_EN
  // Forward the incoming word when it targets the location being read.
  assign read_next = (wce && we && (waddr == raddr)) ? di : array_rdata;
`else
  assign read_next = array_rdata;
`endif

  always_ff @(posedge clk) begin
    if (!aclr) begin
      rdata_q <= '0;
    end else if (rce) begin
      rdata_q <= read_next;
    end
  end

  assign dout = oe ? rdata_q : '0;

endmodule : generic_dpram_1clk

// File: tb/tb_generic_dpram_1clk.sv
// Self-checking bench for generic_dpram_1clk: directed vector table, sweep,
// corner sequences and a randomized phase against a behavioural memory model.
module tb_generic_dpram_1clk;

  localparam int AW = 7;
  localparam int DW = 16;
  localparam int DEPTH = 2 ** AW;

  logic          clk = 1'b0;
  logic          aclr, rce, oe, wce, we;
  logic [AW-1:0] raddr, waddr;
  logic [DW-1:0] di;
  logic [DW-1:0] dout;

  int checks = 0;
  int errors = 0;

  // Behavioural model: plain array plus the word last presented by the read port.
  logic [DW-1:0] model_mem [DEPTH];
  logic [DW-1:0] model_rq;

  typedef struct {
    logic          aclr;
    logic          rce;
    logic          oe;
    logic [AW-1:0] raddr;
    logic          wce;
    logic          we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] di;
    logic [DW-1:0] exp_dout;
    string         name;
  } vec_t;

  vec_t vecs [$];

  generic_dpram_1clk #(.AWIDTH(AW), .DWIDTH(DW)) dut (
    .clk  (clk),
    .aclr (aclr),
    .rce  (rce),
    .oe   (oe),
    .raddr(raddr),
    .dout (dout),
    .wce  (wce),
    .we   (we),
    .waddr(waddr),
    .di   (di)
  );

  always #5 clk = ~clk;

  // Drive one edge worth of inputs, advance the model, settle 1 time unit past the edge.
  task automatic applyStimulus(input logic a, input logic r, input logic o,
                               input logic [AW-1:0] ra, input logic wc,
                               input logic w, input logic [AW-1:0] wa,
                               input logic [DW-1:0] d);
    logic [DW-1:0] old_word;
    aclr = a; rce = r; oe = o; raddr = ra; wce = wc; we = w; waddr = wa; di = d;
    if (!a) begin
      model_rq = '0;
    end else begin
      old_word = model_mem[ra];
      if (r) begin
`ifdef GENERIC_DPRAM_BYPASS_EN
        model_rq = (wc && w && (wa == ra)) ? d : old_word;
`else
        model_rq = old_word;
`endif
      end
      if (wc && w) model_mem[wa] = d;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [DW-1:0] exp);
    checks++;
    if (dout !== exp) begin
      errors++;
      $display("[TB] FAIL %s: dout=%h expected=%h", name, dout, exp);
    end
  endtask

  function automatic vec_t mk(input logic a, input logic r, input logic o,
                              input logic [AW-1:0] ra, input logic wc,
                              input logic w, input logic [AW-1:0] wa,
                              input logic [DW-1:0] d, input logic [DW-1:0] e,
                              input string n);
    vec_t v;
    v.aclr = a; v.rce = r; v.oe = o; v.raddr = ra; v.wce = wc; v.we = w;
    v.waddr = wa; v.di = d; v.exp_dout = e; v.name = n;
    return v;
  endfunction

  initial begin
    logic [DW-1:0] rdw_exp;
    logic [DW-1:0] exp_word;
    logic          a, r, o, wc, w;
    logic [AW-1:0] ra, wa;
    logic [DW-1:0] d;

`ifdef GENERIC_DPRAM_BYPASS_EN
    rdw_exp = 16'h2222;
`else
    rdw_exp = 16'h1111;
`endif
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    model_rq = '0;
    aclr = 1'b0; rce = 1'b0; oe = 1'b1; wce = 1'b0; we = 1'b0;
    raddr = '0; waddr = '0; di = '0;

    //         aclr rce oe raddr  wce we waddr  di        expected
    vecs.push_back(mk(0, 0, 1, 7'h00, 0, 0, 7'h00, 16'h0000, 16'h0000, "reset_edge1"));
    vecs.push_back(mk(0, 0, 1, 7'h00, 0, 0, 7'h00, 16'h0000, 16'h0000, "reset_edge2"));
    vecs.push_back(mk(1, 0, 1, 7'h00, 0, 0, 7'h00, 16'h0000, 16'h0000, "post_reset_idle"));
    vecs.push_back(mk(1, 0, 1, 7'h00, 1, 1, 7'h05, 16'hA5A5, 16'h0000, "write_05"));
    vecs.push_back(mk(1, 1, 1, 7'h05, 0, 0, 7'h00, 16'h0000, 16'hA5A5, "read_05"));
    vecs.push_back(mk(1, 0, 1, 7'h05, 1, 1, 7'h10, 16'h5555, 16'hA5A5, "write_10_hold"));
    vecs.push_back(mk(1, 0, 1, 7'h05, 0, 1, 7'h10, 16'h1234, 16'hA5A5, "wce0_write"));
    vecs.push_back(mk(1, 1, 1, 7'h10, 0, 0, 7'h00, 16'h0000, 16'h5555, "read_10_unchanged"));
    vecs.push_back(mk(1, 0, 1, 7'h05, 0, 0, 7'h00, 16'h0000, 16'h5555, "rce0_hold"));
    vecs.push_back(mk(1, 0, 0, 7'h05, 0, 0, 7'h00, 16'h0000, 16'h0000, "oe0_gate"));
    vecs.push_back(mk(1, 0, 1, 7'h05, 0, 0, 7'h00, 16'h0000, 16'h5555, "oe1_restore"));
    vecs.push_back(mk(1, 0, 1, 7'h00, 1, 1, 7'h20, 16'h1111, 16'h5555, "write_20"));
    vecs.push_back(mk(1, 1, 1, 7'h20, 1, 1, 7'h20, 16'h2222, rdw_exp,   "read_during_write"));
    vecs.push_back(mk(1, 1, 1, 7'h20, 0, 0, 7'h00, 16'h0000, 16'h2222, "read_after_rdw"));
    vecs.push_back(mk(1, 0, 1, 7'h00, 1, 1, 7'h30, 16'hCAFE, 16'h2222, "write_30"));
    vecs.push_back(mk(1, 0, 1, 7'h00, 1, 1, 7'h31, 16'h0BAD, 16'h2222, "write_31"));
    vecs.push_back(mk(0, 1, 1, 7'h30, 1, 1, 7'h30, 16'hBEEF, 16'h0000, "reset_blocks_write"));
    vecs.push_back(mk(1, 0, 1, 7'h00, 0, 0, 7'h00, 16'h0000, 16'h0000, "post_midreset"));
    vecs.push_back(mk(1, 1, 1, 7'h30, 0, 0, 7'h00, 16'h0000, 16'hCAFE, "read_30_survives"));
    vecs.push_back(mk(1, 1, 1, 7'h31, 0, 0, 7'h00, 16'h0000, 16'h0BAD, "read_31_intact"));
    vecs.push_back(mk(1, 1, 1, 7'h05, 0, 0, 7'h00, 16'h0000, 16'hA5A5, "read_05_intact"));

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].aclr, vecs[i].rce, vecs[i].oe, vecs[i].raddr,
                    vecs[i].wce, vecs[i].we, vecs[i].waddr, vecs[i].di);
      checkOutput(vecs[i].name, vecs[i].exp_dout);
    end

    // Full sweep: fill every word, then read back-to-back including the 0x7F -> 0x00 wrap.
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1, 0, 1, '0, 1, 1, AW'(i), DW'(i * 16'h0101));
    end
    for (int i = 0; i <= DEPTH; i++) begin
      applyStimulus(1, 1, 1, AW'(i % DEPTH), 0, 0, '0, '0);
      exp_word = DW'((i % DEPTH) * 16'h0101);
      checkOutput($sformatf("sweep_%0d", i), exp_word);
    end

    // Randomized traffic; frequent address collisions exercise read-during-write.
    for (int n = 0; n < 400; n++) begin
      a  = ($urandom_range(0, 19) != 0);
      r  = $urandom_range(0, 1);
      o  = ($urandom_range(0, 3) != 0);
      wc = $urandom_range(0, 1);
      w  = ($urandom_range(0, 3) != 0);
      wa = AW'($urandom_range(0, DEPTH - 1));
      ra = ($urandom_range(0, 2) == 0) ? wa : AW'($urandom_range(0, DEPTH - 1));
      d  = DW'($urandom);
      applyStimulus(a, r, o, ra, wc, w, wa, d);
      exp_word = o ? model_rq : '0;
      checkOutput($sformatf("random_%0d", n), exp_word);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_generic_dpram_1clk
